// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: FSM states and
// the command / access-width encodings used on the request interface.
package lsu_pkg;

    // Sequencer states: idle, first byte on the bus, second byte on the bus
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StByte0 = 2'd1,
        StByte1 = 2'd2
    } lsu_state_e;

    // Access width (rq_width)
    localparam logic W8  = 1'b0;
    localparam logic W16 = 1'b1;

    // Command (rq_cmd)
    localparam logic LD = 1'b0;
    localparam logic ST = 1'b1;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit that serialises 8- or 16-bit accesses onto a byte-wide
// memory bus. A request is captured in IDLE, then one or two byte
// transfers are run (low byte first). Loads are reassembled little-endian
// and returned with a one-cycle writeback strobe.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        a_rst,

    input  logic        rq_start,
    input  logic        rq_cmd,
    input  logic        rq_width,
    input  logic        rq_tag,
    input  logic [15:0] rq_adr,
    input  logic [15:0] rq_data,
    output logic        lsu_wait,

    output logic [15:0] data_out,
    output logic        data_tag,
    output logic        data_wb,

    output logic [15:0] mem_adr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_ready
);

    lsu_state_e  state_q, state_d;

    // Captured request
    logic        cmd_q, cmd_d;
    logic        width_q, width_d;
    logic        tag_q, tag_d;
    logic [15:0] adr_q, adr_d;
    // Store data; for 16-bit loads the low byte doubles as the byte-0 stash
    logic [15:0] data_q, data_d;

    // Load result
    logic [15:0] data_out_q, data_out_d;
    logic        data_tag_q, data_tag_d;
    logic        data_wb_q, data_wb_d;

    logic        busy;
    logic        in_byte1;
    logic        last_byte;
    logic [15:0] adr_inc;
    logic [15:0] load_result;

    assign busy     = (state_q != StIdle);
    assign in_byte1 = (state_q == StByte1);
    // The transfer in flight is the final one of the access
    assign last_byte = in_byte1 || (width_q == W8);
    // Wraps 0xFFFF -> 0x0000 by truncation
    assign adr_inc  = adr_q + 16'd1;

    // Assembled load value as of the final byte: zero-extended for 8-bit loads
    assign load_result = in_byte1 ? {mem_din, data_q[7:0]} : {8'h00, mem_din};

    // Next-state: request capture, byte sequencing and load assembly
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        width_d    = width_q;
        tag_d      = tag_q;
        adr_d      = adr_q;
        data_d     = data_q;
        data_out_d = data_out_q;
        data_tag_d = data_tag_q;
        data_wb_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (rq_start) begin
                    cmd_d   = rq_cmd;
                    width_d = rq_width;
                    tag_d   = rq_tag;
                    adr_d   = rq_adr;
                    data_d  = rq_data;
                    state_d = StByte0;
                end
            end

            StByte0: begin
                if (mem_ready) begin
                    state_d = (width_q == W16) ? StByte1 : StIdle;
                    if (cmd_q == LD && !last_byte) begin
                        data_d[7:0] = mem_din;
                    end
                end
            end

            StByte1: begin
                if (mem_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Final load byte completes: publish result next cycle
        if (busy && mem_ready && last_byte && cmd_q == LD) begin
            data_out_d = load_result;
            data_tag_d = tag_q;
            data_wb_d  = 1'b1;
        end
    end

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q    <= StIdle;
            cmd_q      <= 1'b0;
            width_q    <= 1'b0;
            tag_q      <= 1'b0;
            adr_q      <= 16'h0000;
            data_q     <= 16'h0000;
            data_out_q <= 16'h0000;
            data_tag_q <= 1'b0;
            data_wb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            width_q    <= width_d;
            tag_q      <= tag_d;
            adr_q      <= adr_d;
            data_q     <= data_d;
            data_out_q <= data_out_d;
            data_tag_q <= data_tag_d;
            data_wb_q  <= data_wb_d;
        end
    end

    // Bus and status outputs decoded from the registered state only
    always_comb begin
        lsu_wait = busy;
        mem_rd   = busy && (cmd_q == LD);
        mem_wr   = busy && (cmd_q == ST);
        mem_adr  = in_byte1 ? adr_inc : adr_q;
        mem_dout = in_byte1 ? data_q[15:8] : data_q[7:0];
        data_out = data_out_q;
        data_tag = data_tag_q;
        data_wb  = data_wb_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-built
// multi-cycle sequences and randomized traffic against a byte-array model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        a_rst;
    logic        rq_start;
    logic        rq_cmd;
    logic        rq_width;
    logic        rq_tag;
    logic [15:0] rq_adr;
    logic [15:0] rq_data;
    logic        lsu_wait;
    logic [15:0] data_out;
    logic        data_tag;
    logic        data_wb;
    logic [15:0] mem_adr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    // bus_mem is what the DUT sees; ref_mem is the model's view
    logic [7:0] bus_mem [0:65535];
    logic [7:0] ref_mem [0:65535];

    typedef struct packed {
        logic        wr;
        logic [15:0] adr;
        logic [7:0]  b;
    } xfer_t;
    xfer_t xfers[$];

    typedef struct {
        logic        cmd;
        logic        width;
        logic        tag;
        logic [15:0] adr;
        logic [15:0] data;
        logic [15:0] exp_out;
        int          exp_wait;
    } vec_t;
    vec_t vecs[9];

    load_store_unit u_dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .rq_start  (rq_start),
        .rq_cmd    (rq_cmd),
        .rq_width  (rq_width),
        .rq_tag    (rq_tag),
        .rq_adr    (rq_adr),
        .rq_data   (rq_data),
        .lsu_wait  (lsu_wait),
        .data_out  (data_out),
        .data_tag  (data_tag),
        .data_wb   (data_wb),
        .mem_adr   (mem_adr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_din = bus_mem[mem_adr];

    // Memory slave: log each completed byte transfer and commit writes
    always @(posedge clk) begin
        if (a_rst && mem_ready && (mem_rd || mem_wr)) begin
            xfers.push_back({mem_wr, mem_adr, mem_wr ? mem_dout : mem_din});
            if (mem_wr) bus_mem[mem_adr] = mem_dout;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] b);
        bus_mem[a] = b;
        ref_mem[a] = b;
    endtask

    // One full request with model checking of bus traffic and result
    task automatic run_req(input logic cmd, input logic width, input logic tag,
                           input logic [15:0] adr, input logic [15:0] data,
                           input bit rnd_ready, output logic [15:0] got_out,
                           output logic got_tag, output int n_wb, output int wait_cyc);
        logic [15:0] a1;
        logic [15:0] exp_val;
        logic [15:0] ea;
        int          cyc;
        int          n_exp;
        bit          both;
        bit          timed_out;
        a1      = adr + 16'd1;
        exp_val = width ? {ref_mem[a1], ref_mem[adr]} : {8'h00, ref_mem[adr]};
        cyc = 0;
        while (lsu_wait && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("idle_before_req", 32'(lsu_wait), 32'd0);
        xfers.delete();
        rq_cmd   = cmd;
        rq_width = width;
        rq_tag   = tag;
        rq_adr   = adr;
        rq_data  = data;
        rq_start = 1'b1;
        tick();
        rq_start = 1'b0;
        rq_cmd   = 1'($urandom);
        rq_width = 1'($urandom);
        rq_tag   = 1'($urandom);
        rq_adr   = 16'($urandom);
        rq_data  = 16'($urandom);
        n_wb     = 0;
        wait_cyc = 0;
        both     = 1'b0;
        got_out  = data_out;
        got_tag  = data_tag;
        while (lsu_wait && wait_cyc < 50) begin
            if (mem_rd && mem_wr) both = 1'b1;
            mem_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
            tick();
            wait_cyc++;
            if (data_wb) begin
                n_wb++;
                got_out = data_out;
                got_tag = data_tag;
            end
        end
        timed_out = (wait_cyc >= 50);
        chk("busy_timeout", 32'(timed_out), 32'd0);
        chk("rd_wr_exclusive", 32'(both), 32'd0);
        tick();
        chk("wb_single_cycle", 32'(data_wb), 32'd0);
        chk("wb_count", 32'(n_wb), (cmd == LD) ? 32'd1 : 32'd0);
        n_exp = width ? 2 : 1;
        chk("xfer_count", 32'(xfers.size()), 32'(n_exp));
        for (int i = 0; i < xfers.size() && i < n_exp; i++) begin
            ea = (i == 0) ? adr : a1;
            chk("xfer_dir", 32'(xfers[i].wr), 32'(cmd));
            chk("xfer_adr", 32'(xfers[i].adr), 32'(ea));
            if (cmd == ST) chk("xfer_wbyte", 32'(xfers[i].b),
                               (i == 0) ? 32'(data[7:0]) : 32'(data[15:8]));
        end
        if (cmd == LD) begin
            chk("load_data", 32'(got_out), 32'(exp_val));
            chk("load_tag", 32'(got_tag), 32'(tag));
        end else begin
            ref_mem[adr] = data[7:0];
            if (width) ref_mem[a1] = data[15:8];
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] got_out;
        logic        got_tag;
        int          n_wb;
        int          wait_cyc;
        int          mism;
        bit          flag_a;
        bit          flag_b;
        int          wb_cyc[$];
        logic        wb_tag[$];
        logic [15:0] wb_dat[$];
        logic        r_cmd;
        logic        r_width;
        logic        r_tag;
        logic [15:0] r_adr;
        logic [15:0] r_data;

        a_rst     = 1'b1;
        rq_start  = 1'b0;
        rq_cmd    = 1'b0;
        rq_width  = 1'b0;
        rq_tag    = 1'b0;
        rq_adr    = 16'h0000;
        rq_data   = 16'h0000;
        mem_ready = 1'b0;
        for (int a = 0; a < 65536; a++) begin
            b = 8'($urandom);
            bus_mem[a] = b;
            ref_mem[a] = b;
        end
        #1 a_rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_lsu_wait", 32'(lsu_wait), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_data_wb", 32'(data_wb), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_tag", 32'(data_tag), 32'd0);
        a_rst = 1'b1;
        tick();

        // Directed vector table, mem_ready tied high
        preload(16'h1234, 8'hAB);
        preload(16'hFFFF, 8'h34);
        preload(16'h0000, 8'h12);
        vecs[0] = '{LD, W8,  1'b1, 16'h1234, 16'h0000, 16'h00AB, 1};
        vecs[1] = '{LD, W16, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 2};
        vecs[2] = '{ST, W16, 1'b0, 16'h0300, 16'hBEEF, 16'h0000, 2};
        vecs[3] = '{LD, W16, 1'b1, 16'h0300, 16'h0000, 16'hBEEF, 2};
        vecs[4] = '{ST, W8,  1'b1, 16'h0301, 16'h5A77, 16'h0000, 1};
        vecs[5] = '{LD, W16, 1'b0, 16'h0300, 16'h0000, 16'h77EF, 2};
        vecs[6] = '{LD, W8,  1'b1, 16'h0301, 16'h0000, 16'h0077, 1};
        vecs[7] = '{ST, W8,  1'b0, 16'hFFFF, 16'h1111, 16'h0000, 1};
        vecs[8] = '{LD, W16, 1'b1, 16'hFFFF, 16'h0000, 16'h1211, 2};
        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i].cmd, vecs[i].width, vecs[i].tag, vecs[i].adr, vecs[i].data,
                    1'b0, got_out, got_tag, n_wb, wait_cyc);
            chk($sformatf("vec%0d_wait", i), 32'(wait_cyc), 32'(vecs[i].exp_wait));
            if (vecs[i].cmd == LD) begin
                chk($sformatf("vec%0d_out", i), 32'(got_out), 32'(vecs[i].exp_out));
                chk($sformatf("vec%0d_tag", i), 32'(got_tag), 32'(vecs[i].tag));
            end
        end

        // 16-bit store with byte 0 stalled for three cycles
        rq_cmd = ST; rq_width = W16; rq_tag = 1'b0;
        rq_adr = 16'h0200; rq_data = 16'hBEEF;
        rq_start = 1'b1; mem_ready = 1'b0;
        tick();
        rq_start = 1'b0;
        flag_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("stall_wr", 32'(mem_wr), 32'd1);
            chk("stall_adr", 32'(mem_adr), 32'h0200);
            chk("stall_byte", 32'(mem_dout), 32'hEF);
            if (data_wb) flag_a = 1'b1;
            mem_ready = (k == 3);
            tick();
        end
        chk("stall_b1_wr", 32'(mem_wr), 32'd1);
        chk("stall_b1_adr", 32'(mem_adr), 32'h0201);
        chk("stall_b1_byte", 32'(mem_dout), 32'hBE);
        if (data_wb) flag_a = 1'b1;
        tick();
        if (data_wb) flag_a = 1'b1;
        chk("stall_done", 32'(lsu_wait), 32'd0);
        chk("store_no_wb", 32'(flag_a), 32'd0);
        ref_mem[16'h0200] = 8'hEF;
        ref_mem[16'h0201] = 8'hBE;

        // Request held during busy; second load issued on the writeback cycle
        preload(16'h0040, 8'h11);
        preload(16'h0041, 8'h22);
        preload(16'h0080, 8'h99);
        rq_cmd = LD; rq_width = W16; rq_tag = 1'b0; rq_adr = 16'h0040;
        rq_start = 1'b1; mem_ready = 1'b1;
        tick();
        chk("hold_b0_adr", 32'(mem_adr), 32'h0040);
        rq_width = W8; rq_tag = 1'b1; rq_adr = 16'h0080;
        tick();
        chk("hold_b1_adr", 32'(mem_adr), 32'h0041);
        chk("hold_b1_rd", 32'(mem_rd), 32'd1);
        tick();
        chk("hold_wb1", 32'(data_wb), 32'd1);
        chk("hold_out1", 32'(data_out), 32'h2211);
        chk("hold_tag1", 32'(data_tag), 32'd0);
        chk("hold_idle", 32'(lsu_wait), 32'd0);
        tick();
        chk("second_adr", 32'(mem_adr), 32'h0080);
        chk("second_busy", 32'(lsu_wait), 32'd1);
        chk("second_wb_low", 32'(data_wb), 32'd0);
        rq_start = 1'b0;
        tick();
        chk("second_wb", 32'(data_wb), 32'd1);
        chk("second_out", 32'(data_out), 32'h0099);
        chk("second_tag", 32'(data_tag), 32'd1);
        tick();

        // Reset during byte 1 of a 16-bit load
        rq_cmd = LD; rq_width = W16; rq_tag = 1'b1; rq_adr = 16'h0050;
        rq_start = 1'b1; mem_ready = 1'b1;
        tick();
        rq_start = 1'b0;
        tick();
        chk("abort_pre_adr", 32'(mem_adr), 32'h0051);
        #2 a_rst = 1'b0;
        #1;
        chk("abort_rd", 32'(mem_rd), 32'd0);
        chk("abort_wait", 32'(lsu_wait), 32'd0);
        chk("abort_wb", 32'(data_wb), 32'd0);
        chk("abort_out", 32'(data_out), 32'd0);
        chk("abort_tag", 32'(data_tag), 32'd0);
        @(negedge clk);
        a_rst = 1'b1;
        flag_a = 1'b0;
        flag_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (data_wb) flag_a = 1'b1;
            if (lsu_wait || mem_rd || mem_wr) flag_b = 1'b1;
        end
        chk("abort_no_wb", 32'(flag_a), 32'd0);
        chk("abort_no_resume", 32'(flag_b), 32'd0);
        run_req(LD, W8, 1'b1, 16'h0040, 16'h0000, 1'b0, got_out, got_tag, n_wb, wait_cyc);
        chk("post_rst_wait", 32'(wait_cyc), 32'd1);
        chk("post_rst_out", 32'(got_out), 32'h0011);

        // Back-to-back 8-bit loads
        preload(16'h0010, 8'hA1);
        preload(16'h0011, 8'hB2);
        rq_cmd = LD; rq_width = W8; rq_tag = 1'b0; rq_adr = 16'h0010;
        rq_start = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data_wb) begin
                wb_cyc.push_back(i);
                wb_tag.push_back(data_tag);
                wb_dat.push_back(data_out);
            end
            if (i == 0) begin
                rq_tag = 1'b1;
                rq_adr = 16'h0011;
            end
            if (i == 2) rq_start = 1'b0;
        end
        chk("b2b_count", 32'(wb_cyc.size()), 32'd2);
        if (wb_cyc.size() == 2) begin
            chk("b2b_spacing", 32'(wb_cyc[1] - wb_cyc[0]), 32'd2);
            chk("b2b_tag0", 32'(wb_tag[0]), 32'd0);
            chk("b2b_tag1", 32'(wb_tag[1]), 32'd1);
            chk("b2b_dat0", 32'(wb_dat[0]), 32'h00A1);
            chk("b2b_dat1", 32'(wb_dat[1]), 32'h00B2);
        end

        // Randomized traffic with random bus stalls
        for (int n = 0; n < 150; n++) begin
            r_cmd   = 1'($urandom);
            r_width = 1'($urandom);
            r_tag   = 1'($urandom);
            r_adr   = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                  : 16'($urandom_range(0, 63));
            r_data  = 16'($urandom);
            run_req(r_cmd, r_width, r_tag, r_adr, r_data, 1'b1,
                    got_out, got_tag, n_wb, wait_cyc);
        end

        mism = 0;
        for (int a = 0; a < 65536; a++) begin
            if (bus_mem[a] !== ref_mem[a]) mism++;
        end
        chk("mem_image", 32'(mism), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port a_rst  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port rq_start  input  1  a memory request is presented this cycle.
REQ-004 SHALL have port rq_cmd  input  1  1 = store, 0 = load.
REQ-005 SHALL have port rq_width  input  1  1 = 16-bit access, 0 = 8-bit access.
REQ-006 SHALL have port rq_tag  input  1  station tag, returned with load data.
REQ-007 SHALL have port rq_adr  input  16  effective address from the AGU.
REQ-008 SHALL have port rq_data  input  16  store data; bits 7:0 only for 8-bit stores.
REQ-009 SHALL have port lsu_wait  output  1  busy; the requester holds its request while high.
REQ-010 SHALL have port data_out  output  16  load result.
REQ-011 SHALL have port data_tag  output  1  tag of data_out.
REQ-012 SHALL have port data_wb  output  1  one-cycle load writeback strobe.
REQ-013 SHALL have port mem_adr  output  16  byte address on the memory bus.
REQ-014 SHALL have port mem_rd  output  1  byte read request.
REQ-015 SHALL have port mem_wr  output  1  byte write request.
REQ-016 SHALL have port mem_dout  output  8  write byte.
REQ-017 SHALL have port mem_din  input  8  read byte.
REQ-018 SHALL have port mem_ready  input  1  a byte transfer completes at an edge where this is high while mem_rd or mem_wr is high.

Function
REQ-019 SHALL implement three states: IDLE, BYTE0 and BYTE1.
REQ-020 In IDLE with rq_start=1, SHALL capture cmd, width, tag, adr and data at the edge and enter BYTE0; in IDLE with rq_start=0, SHALL stay in IDLE.
REQ-021 lsu_wait SHALL equal (state != IDLE), combinationally; rq_start SHALL be ignored while busy.
REQ-022 In BYTE0, SHALL drive mem_adr = captured adr, and mem_dout = data[7:0] for stores.
REQ-023 In BYTE1, SHALL drive mem_adr = adr + 1, mod 2^16 (0xFFFF wraps to 0x0000), and mem_dout = data[15:8] for stores.
REQ-024 mem_rd (load) or mem_wr (store) SHALL be high throughout BYTE0/BYTE1 and low in IDLE; never both high.
REQ-025 SHALL hold state while mem_ready=0, with bus outputs stable.
REQ-026 BYTE0 with mem_ready=1 SHALL go to BYTE1 if width=1, else to IDLE; BYTE1 with mem_ready=1 SHALL go to IDLE.
REQ-027 Load bytes SHALL be latched little-endian: BYTE0 gives result[7:0], BYTE1 gives result[15:8].
REQ-028 An 8-bit load SHALL zero-extend: data_out[15:8] = 0x00.
REQ-029 On completion of the final load byte, SHALL register data_out and data_tag and assert data_wb for exactly the following cycle.
REQ-030 data_out and data_tag SHALL hold their last value otherwise; stores SHALL never assert data_wb.
REQ-031 A new request SHALL be acceptable in the same cycle that data_wb is high.
REQ-032 Latency with mem_ready tied high: 8-bit load, data_wb 2 cycles after the accept edge; 16-bit load, 3 cycles; store, lsu_wait high for 1 cycle (8-bit) or 2 cycles (16-bit).

Reset
REQ-033 a_rst low SHALL immediately force state=IDLE, mem_rd=0, mem_wr=0, data_wb=0, data_out=0x0000, data_tag=0, and all captured request registers to 0, including mid-operation.
REQ-034 After reset release, SHALL accept a request at the first edge with rq_start=1; an aborted access SHALL NOT be resumed.

Structure
REQ-035 State encoding and width constants (W8=0, W16=1) and command constants (LD=0, ST=1) SHALL live in shared package lsu_pkg.
REQ-036 SHALL be a single module with no sub-module; the address incrementer is inline.

Verification
REQ-037 8-bit load, adr=0x1234, tag=1, mem_din=0xAB, ready high -> mem_rd at 0x1234 for 1 cycle; data_wb 1 cycle with data_out=0x00AB, data_tag=1.
REQ-038 16-bit load, adr=0xFFFF, bytes 0x34 then 0x12 -> reads 0xFFFF then 0x0000; data_out=0x1234; lsu_wait high for exactly 2 cycles.
REQ-039 16-bit store, adr=0x0200, data=0xBEEF, mem_ready low for 3 cycles on byte 0 -> 0xEF held at 0x0200 for 4 cycles, then 0xBE at 0x0201; data_wb never high.
REQ-040 rq_start held high with new fields during busy -> fields ignored; a second load is issued on the data_wb cycle and completes correctly.
REQ-041 a_rst low during BYTE1 of a 16-bit load -> mem_rd=0, lsu_wait=0, data_wb=0 at once; no writeback after release.
REQ-042 Back-to-back 8-bit loads, tag 0 then tag 1 -> two data_wb pulses, 2 cycles apart, with tags 0 and 1 in order.
